// File: rtl/xor5_parity_sequencer.sv
// xor5_parity_sequencer
//   Shares one 5-input XOR parity unit among NREQ requesters. A round-robin
//   arbiter accepts one WIDTH-bit word at a time. The word is walked through
//   the xor5 unit in 5-bit chunks, one chunk per cycle, and the accumulated
//   parity is returned with the requester id on a valid/ready response port.
//
// Parameters
//   NREQ   number of requesters (>=1)
//   WIDTH  data word width per requester (>=1)
//
// Ports
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   req_valid   [NREQ]        per-requester request valid
//   req_data    [NREQ*WIDTH]  requester i word at [i*WIDTH +: WIDTH]
//   req_ready   [NREQ]        one-hot grant, combinational, only in IDLE
//   rsp_valid   response valid (held until rsp_ready)
//   rsp_ready   response consumer ready
//   rsp_parity  XOR of all WIDTH bits of the served word
//   rsp_id      [IDW]         index of the served requester
//   stat_jobs   [16]          completed response handshakes, saturating
//                             (present only with XOR5SEQ_STATS_EN defined)
//   busy        high whenever the FSM is not in IDLE
//
// Build option
//   XOR5SEQ_STATS_EN  adds the stat_jobs counter port.

// Shared parity datapath: one 5-bit chunk per use.
module xor5_unit (
  input  logic [4:0] din,
  output logic       par
);
  assign par = ^din;
endmodule

module xor5_parity_sequencer #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 20
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NREQ-1:0]                        req_valid,
  input  logic [NREQ*WIDTH-1:0]                  req_data,
  output logic [NREQ-1:0]                        req_ready,
  output logic                                   rsp_valid,
  input  logic                                   rsp_ready,
  output logic                                   rsp_parity,
  output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] rsp_id,
`ifdef XOR5SEQ_STATS_EN
  output logic [15:0]                            stat_jobs,
`endif
  output logic                                   busy
);

  localparam int CHUNKS = (WIDTH + 4) / 5;
  localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNTW   = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef struct packed {
    logic [WIDTH-1:0] word;
    logic [IDW-1:0]   id;
  } job_t;

  logic [1:0]      state;
  job_t            job;
  logic            acc;
  logic [CNTW-1:0] cnt;
  logic [IDW-1:0]  ptr;   // last served requester; scan starts at ptr+1

  // Per-lane view of the flat request bus.
  logic [NREQ-1:0][WIDTH-1:0] lane_data;
  assign lane_data = req_data;

  // ---------------------------------------------------------------------
  // Round-robin grant: first valid requester at ptr+1, ptr+2, ... mod NREQ
  // ---------------------------------------------------------------------
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  gid;
  logic            gfound;

  always_comb begin
    logic [IDW-1:0] idx;
    grant  = '0;
    gid    = '0;
    gfound = 1'b0;
    idx    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      if (!gfound && req_valid[idx]) begin
        grant[idx] = 1'b1;
        gid        = idx;
        gfound     = 1'b1;
      end
    end
  end

  // Grants are only offered in IDLE, and never while reset is held (the
  // state register is already IDLE then, so gate explicitly).
  assign req_ready = (rst_n && state == S_IDLE) ? grant : '0;
  assign busy      = (state != S_IDLE);

  // ---------------------------------------------------------------------
  // Chunk selection: zero-pad the word up to CHUNKS*5 bits, then index.
  // ---------------------------------------------------------------------
  logic [CHUNKS*5-1:0]      padded;
  logic [CHUNKS-1:0][4:0]   chunks;
  logic [4:0]               cur_chunk;
  logic                     cpar;

  always_comb begin
    padded              = '0;
    padded[WIDTH-1:0]   = job.word;
  end

  assign chunks    = padded;
  assign cur_chunk = chunks[cnt];

  xor5_unit u_xor5 (
    .din (cur_chunk),
    .par (cpar)
  );

  // ---------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      job        <= '0;
      acc        <= 1'b0;
      cnt        <= '0;
      ptr        <= IDW'(NREQ - 1);
      rsp_valid  <= 1'b0;
      rsp_parity <= 1'b0;
      rsp_id     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // gfound in IDLE is exactly the req_valid & req_ready handshake.
          if (gfound) begin
            job.word <= lane_data[gid];
            job.id   <= gid;
            acc      <= 1'b0;
            cnt      <= '0;
            state    <= S_RUN;
          end
        end
        S_RUN: begin
          acc <= acc ^ cpar;
          cnt <= cnt + 1'b1;
          // Last chunk: fold it straight into the response register so the
          // response appears CHUNKS edges after the accept.
          if (cnt == CNTW'(CHUNKS - 1)) begin
            state      <= S_DONE;
            rsp_valid  <= 1'b1;
            rsp_parity <= acc ^ cpar;
            rsp_id     <= job.id;
          end
        end
        S_DONE: begin
          if (rsp_ready) begin
            ptr       <= job.id;
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef XOR5SEQ_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_jobs <= '0;
    end else if (rsp_valid && rsp_ready && stat_jobs != 16'hFFFF) begin
      stat_jobs <= stat_jobs + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_xor5_parity_sequencer.sv
// Directed bench for xor5_parity_sequencer: default build (NREQ=4,
// WIDTH=20) plus a small NREQ=1, WIDTH=7 instance for the padded-chunk case.
module tb_xor5_parity_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main instance
  logic [3:0]  req_valid;
  logic [79:0] req_data;
  logic [3:0]  req_ready;
  logic        rsp_valid, rsp_ready, rsp_parity;
  logic [1:0]  rsp_id;
  logic        busy;
`ifdef XOR5SEQ_STATS_EN
  logic [15:0] stat_jobs;
  logic [15:0] stat2;
`endif

  // Small instance
  logic       r2_valid;
  logic [6:0] r2_data;
  logic       r2_ready, s2_valid, s2_ready, s2_parity;
  logic       s2_id;
  logic       busy2;

  xor5_parity_sequencer #(.NREQ(4), .WIDTH(20)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_parity (rsp_parity),
    .rsp_id     (rsp_id),
`ifdef XOR5SEQ_STATS_EN
    .stat_jobs  (stat_jobs),
`endif
    .busy       (busy)
  );

  xor5_parity_sequencer #(.NREQ(1), .WIDTH(7)) dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (r2_valid),
    .req_data   (r2_data),
    .req_ready  (r2_ready),
    .rsp_valid  (s2_valid),
    .rsp_ready  (s2_ready),
    .rsp_parity (s2_parity),
    .rsp_id     (s2_id),
`ifdef XOR5SEQ_STATS_EN
    .stat_jobs  (stat2),
`endif
    .busy       (busy2)
  );

  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int i, input logic [19:0] d);
    req_data[i*20 +: 20] = d;
  endtask

  // Serve one job on the main instance. Inputs are already driven; the
  // granted requester is exp_id. drop clears its valid after the accept.
  task automatic serve(input int exp_id, input logic exp_par, input bit drop, input int stall);
    int lat;
    chk("grant", 32'(req_ready), 32'(1 << exp_id));
    chk("busy_idle", 32'(busy), 32'd0);
    step();                                   // accept edge
    if (drop) req_valid[exp_id] = 1'b0;
    chk("busy_run", 32'(busy), 32'd1);
    chk("ready_run", 32'(req_ready), 32'd0);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      step();
      lat++;
    end
    chk("latency", 32'(lat), 32'd4);
    chk("parity", 32'(rsp_parity), 32'(exp_par));
    chk("id", 32'(rsp_id), 32'(exp_id));
    for (int c = 0; c < stall; c++) begin
      step();
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      chk("stall_parity", 32'(rsp_parity), 32'(exp_par));
      chk("stall_id", 32'(rsp_id), 32'(exp_id));
      chk("stall_ready", 32'(req_ready), 32'd0);
      chk("stall_busy", 32'(busy), 32'd1);
    end
    rsp_ready = 1'b1;
    step();                                   // response handshake
    rsp_ready = 1'b0;
    chk("rsp_drop", 32'(rsp_valid), 32'd0);
    chk("busy_after", 32'(busy), 32'd0);
  endtask

  task automatic serve2(input logic [6:0] d, input logic exp_par);
    int lat;
    r2_data  = d;
    r2_valid = 1'b1;
    #1;
    chk("w7_grant", 32'(r2_ready), 32'd1);
    step();
    r2_valid = 1'b0;
    lat = 0;
    while (!s2_valid && lat < 20) begin
      step();
      lat++;
    end
    chk("w7_latency", 32'(lat), 32'd2);
    chk("w7_parity", 32'(s2_parity), 32'(exp_par));
    chk("w7_id", 32'(s2_id), 32'd0);
    s2_ready = 1'b1;
    step();
    s2_ready = 1'b0;
  endtask

  initial begin
    req_valid = 4'b1111;
    req_data  = '0;
    rsp_ready = 1'b0;
    r2_valid  = 1'b0;
    r2_data   = '0;
    s2_ready  = 1'b0;

    // Reset state, with all requests asserted
    #2;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_parity", 32'(rsp_parity), 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    chk("rst_ready2", 32'(r2_ready), 32'd0);
`ifdef XOR5SEQ_STATS_EN
    chk("rst_stats", 32'(stat_jobs), 32'd0);
`endif
    req_valid = 4'b0000;
    step();
    rsp_ready = 1'b0;
    rst_n = 1'b1;
    step();

    // Single-bit word on requester 0
    set_word(0, 20'h00001); req_valid = 4'b0001; #1;
    serve(0, 1'b1, 1'b1, 0);
    // All ones / low three bits / top bit, on assorted requesters
    set_word(2, 20'hFFFFF); req_valid = 4'b0100; #1;
    serve(2, 1'b0, 1'b1, 0);
    set_word(1, 20'h00007); req_valid = 4'b0010; #1;
    serve(1, 1'b1, 1'b1, 0);
    set_word(3, 20'h80000); req_valid = 4'b1000; #1;
    serve(3, 1'b1, 1'b1, 0);

    // Round robin from reset with every requester held valid
    rst_n = 1'b0; #1; rst_n = 1'b1;
    set_word(0, 20'h00003);
    set_word(1, 20'h00010);
    set_word(2, 20'hF0F01);
    set_word(3, 20'h00011);
    req_valid = 4'b1111; #1;
    serve(0, 1'b0, 1'b0, 0);
    serve(1, 1'b1, 1'b0, 0);
    serve(2, 1'b1, 1'b0, 0);
    serve(3, 1'b0, 1'b0, 0);
    serve(0, 1'b0, 1'b0, 0);
`ifdef XOR5SEQ_STATS_EN
    chk("stat_jobs", 32'(stat_jobs), 32'd5);
`endif

    // Back-pressure: DONE held for 10 cycles, others still requesting
    serve(1, 1'b1, 1'b0, 10);
    req_valid = 4'b0000;

    // Reset in the middle of RUN
    set_word(3, 20'h00001); req_valid = 4'b1000; #1;
    chk("mid_grant", 32'(req_ready), 32'b1000);
    step();
    step();
    step();
    chk("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    step();
    rst_n = 1'b1;
    set_word(0, 20'h00007);
    set_word(1, 20'h00010);
    req_valid = 4'b0011; #1;
    serve(0, 1'b1, 1'b1, 0);
    serve(1, 1'b1, 1'b1, 0);
    chk("drained", 32'(rsp_valid), 32'd0);

    // Narrow build: 7-bit word, two chunks, top chunk padded
    serve2(7'b1000000, 1'b1);
    serve2(7'b1010101, 1'b0);
    serve2(7'b0010000, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
